// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg
// Shared definitions for the chunked adder blocks. The controller state
// encoding and the default operand and chunk widths live here, so every
// adder in the slice uses the same values.
// Ports: none (package only).
package chunked_adder_pkg;

  // Controller states: waiting for operands, rippling chunks, holding result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_CHUNK = 8;

endpackage

// File: rtl/chunked_adder_chunk.sv
// chunk_adder
// Combinational WIDTH-bit ripple-carry adder made from 1-bit full-adder cells.
// The top level uses one of these per clock to add one chunk.
// Ports:
//   a, b   : chunk operands
//   ci     : carry into bit 0
//   s      : chunk sum
//   co     : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow)
module chunk_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [WIDTH:0] c;

  assign c[0] = ci;

  // One full-adder cell per bit; c[i] is the carry into bit i
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder
// Multi-cycle adder/subtractor that adds CHUNK bits per clock, LSB chunk
// first, so a WIDTH-bit result takes WIDTH/CHUNK cycles. It accepts operands
// with a valid/ready handshake and returns the result the same way.
// Ports:
//   Clk, Rst           : clock, asynchronous active-high reset
//   InValid, InReady   : operand handshake (InReady only in IDLE)
//   A, B, Ci, Sub      : operands, carry/borrow in, 1 = subtract
//   OutValid, OutReady : result handshake (OutValid only in DONE)
//   S, Co, Ovf         : result, carry out (1 = no borrow), signed overflow
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co, chunk_cmsb;

  // Operands are shifted right each ADD cycle, so the current chunk is
  // always the bottom CHUNK bits and no wide mux is needed.
  chunk_adder #(.WIDTH(CHUNK)) u_chunk (
    .a     (op_a[CHUNK-1:0]),
    .b     (op_b[CHUNK-1:0]),
    .ci    (carry),
    .s     (chunk_s),
    .co    (chunk_co),
    .c_msb (chunk_cmsb)
  );

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs. Leaving DONE always passes through
  // IDLE, so an operation never starts on the edge a result is taken.
  always_comb begin
    state_next = state;
    InReady    = 1'b0;
    OutValid   = 1'b0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) state_next = ADD;
      end
      ADD: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Subtraction is done as A + ~B + 1, so B is inverted and the
  // borrow-in becomes an inverted carry-in at capture time. Co and Ovf are
  // only written on the last chunk, and S only during ADD, so a finished
  // result stays put through DONE and IDLE until the next operation.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Co    <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            op_a  <= A;
            op_b  <= B ^ {WIDTH{Sub}};
            carry <= Ci ^ Sub;
            cnt   <= '0;
          end
        end
        ADD: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          carry <= chunk_co;
          cnt   <= cnt + 1'b1;
          for (int k = 0; k < N; k++) begin
            if (cnt == CNT_W'(k)) S[k*CHUNK +: CHUNK] <= chunk_s;
          end
          if (cnt == LAST) begin
            Co  <= chunk_co;
            Ovf <= chunk_co ^ chunk_cmsb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 64, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Clk  input  1  rising-edge clock; the block has one clock.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 InValid  input  1  operands presented.
REQ-006 InReady  output  1  block can accept operands.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Ci  input  1  carry-in for add; borrow-in for subtract.
REQ-010 Sub  input  1  0 = A+B+Ci, 1 = A-B-Ci.
REQ-011 OutValid  output  1  result available.
REQ-012 OutReady  input  1  consumer accepts result.
REQ-013 S  output  WIDTH  sum/difference.
REQ-014 Co  output  1  carry-out (subtract: 1 = no borrow).
REQ-015 Ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, ADD, DONE.
REQ-017 InReady SHALL be 1 only in IDLE; OutValid SHALL be 1 only in DONE.
REQ-018 In IDLE, InValid=1 SHALL capture A, B^{WIDTH{Sub}}, and carry=Ci^Sub; chunk counter cleared; next state ADD.
REQ-019 In ADD, each cycle SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1, LSB chunk first) plus the carry register, write the chunk into S, and update carry.
REQ-020 After N=WIDTH/CHUNK ADD cycles the FSM SHALL enter DONE; OutValid SHALL rise exactly N cycles after the accepting edge.
REQ-021 CHUNK=WIDTH SHALL give N=1 (single ADD cycle).
REQ-022 Co SHALL be the carry out of bit WIDTH-1; Ovf SHALL be carry-into-MSB XOR carry-out-of-MSB, both registered at the final chunk.
REQ-023 A, B, Ci, Sub and InValid changes during ADD/DONE SHALL be ignored.
REQ-024 In DONE, S, Co, Ovf SHALL hold stable until OutReady=1; DONE with OutReady=1 SHALL return to IDLE on that edge.
REQ-025 No overlap: a new operation SHALL NOT be accepted in the cycle OutValid handshakes; InReady rises the following cycle.
REQ-026 S, Co, Ovf SHALL keep the last result in IDLE until the next accept.

Reset
REQ-027 Rst=1 SHALL immediately force state IDLE, InReady=1, OutValid=0, S=0, Co=0, Ovf=0, carry and counter 0.
REQ-028 Reset during ADD or DONE SHALL abort the operation with no partial result visible after release.

Structure
REQ-029 State encoding and default WIDTH/CHUNK values SHALL live in a shared package/include used by all adder blocks.
REQ-030 The per-cycle CHUNK-bit ripple adder SHALL be one sub-module, chunk_adder (inputs a, b, ci; outputs s, co, c_msb), built from 1-bit full-adder cells.
REQ-031 The chunk counter SHALL be clog2(N) bits, minimum 1.

Verification (WIDTH=64, CHUNK=8)
REQ-032 A=1, B=0, Ci=0, Sub=0 -> OutValid after 8 cycles, S=1, Co=0, Ovf=0.
REQ-033 A=0xFFFF_FFFF_FFFF_FFFF, B=1, Ci=0 -> S=0, Co=1, Ovf=0.
REQ-034 A=0x7FFF_FFFF_FFFF_FFFF, B=0, Ci=1 -> S=0x8000_0000_0000_0000, Co=0, Ovf=1.
REQ-035 Sub=1, A=5, B=7, Ci=0 -> S=0xFFFF_FFFF_FFFF_FFFE, Co=0, Ovf=0.
REQ-036 OutReady held 0 for 5 cycles in DONE with InValid=1 -> S stable, InReady=0, no new capture; OutReady=1 -> IDLE next cycle.
REQ-037 Rst pulsed on the 3rd ADD cycle -> OutValid=0, InReady=1, S=0 while Rst=1; next operation A=2, B=2 -> S=4 after 8 cycles.
